// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between the dump unit (ch0)
// and the command/response path (ch1), with per-frame grant locking.
module uart_tx_arbiter #(
    parameter int unsigned UART_DATA_SIZE = 8,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned LOCK_TIMEOUT   = 1024
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic [1:0]                i_valid,
    input  logic [UART_DATA_SIZE-1:0] i_data0,
    input  logic [UART_DATA_SIZE-1:0] i_data1,
    input  logic [1:0]                i_lock,
    input  logic                      i_tx_done,
    output logic [1:0]                o_ready,
    output logic [UART_DATA_SIZE-1:0] o_tx_data,
    output logic                      o_tx_start,
    output logic                      o_grant,
    output logic                      o_busy,
    output logic [1:0]                o_overrun,
    output logic                      o_lock_timeout
);

    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned LOCK_W = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [1:0]                valid_d;
    logic [1:0]                pending;
    logic [1:0]                hlock;
    logic [UART_DATA_SIZE-1:0] hold0;
    logic [UART_DATA_SIZE-1:0] hold1;
    logic                      lock_vld;
    logic                      lock_owner;
    logic [GAP_W-1:0]          gap_cnt;
    logic [LOCK_W-1:0]         lock_cnt;

    logic [1:0] edge_c, clear_c, take_c, ovr_c;
    logic       done_c, pick_c, sel_c, gap_end_c, lock_run_c, lock_expire_c;

    // Capture, arbitration and lock-timeout decode plus next-state logic
    always_comb begin
        edge_c        = i_valid & ~valid_d;
        done_c        = (state_q == BUSY) && i_tx_done;
        clear_c       = 2'b00;
        if (done_c) begin
            clear_c = o_grant ? 2'b10 : 2'b01;
        end
        // A new edge on a slot being freed this cycle is accepted, not an overrun
        take_c        = edge_c & (~pending | clear_c);
        ovr_c         = edge_c & pending & ~clear_c;
        gap_end_c     = (32'(gap_cnt) == GAP_CYCLES - 32'd1);
        lock_run_c    = lock_vld && (state_q == IDLE) && !pending[lock_owner];
        lock_expire_c = lock_run_c && (32'(lock_cnt) == LOCK_TIMEOUT - 32'd1);

        pick_c = 1'b0;
        sel_c  = 1'b0;
        if (lock_vld) begin
            pick_c = pending[lock_owner];
            sel_c  = lock_owner;
        end else if (pending == 2'b11) begin
            pick_c = 1'b1;
            sel_c  = ~o_grant;
        end else begin
            pick_c = |pending;
            sel_c  = pending[1];
        end

        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_c) state_d = START;
            START:   state_d = BUSY;
            BUSY:    if (i_tx_done) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:     if (gap_end_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Holding slots, lock tracking and registered outputs
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            valid_d        <= 2'b00;
            pending        <= 2'b00;
            hlock          <= 2'b00;
            hold0          <= '0;
            hold1          <= '0;
            lock_vld       <= 1'b0;
            lock_owner     <= 1'b0;
            gap_cnt        <= '0;
            lock_cnt       <= '0;
            o_ready        <= 2'b11;
            o_tx_data      <= '0;
            o_tx_start     <= 1'b0;
            o_grant        <= 1'b0;
            o_busy         <= 1'b0;
            o_overrun      <= 2'b00;
            o_lock_timeout <= 1'b0;
        end else begin
            valid_d   <= i_valid;
            pending   <= (pending & ~clear_c) | take_c;
            hlock     <= (hlock & ~take_c) | (i_lock & take_c);
            o_overrun <= o_overrun | ovr_c;
            if (take_c[0]) hold0 <= i_data0;
            if (take_c[1]) hold1 <= i_data1;
            o_ready    <= ~pending;
            o_tx_start <= (state_d == START);
            o_busy     <= (state_d != IDLE);

            if ((state_q == IDLE) && pick_c) begin
                o_tx_data <= sel_c ? hold1 : hold0;
                o_grant   <= sel_c;
            end

            if (state_q == GAP) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end else begin
                gap_cnt <= '0;
            end

            if (done_c) begin
                lock_vld   <= hlock[o_grant];
                lock_owner <= o_grant;
            end else if (lock_expire_c) begin
                lock_vld <= 1'b0;
            end

            if (!lock_run_c || lock_expire_c) begin
                lock_cnt <= '0;
            end else begin
                lock_cnt <= lock_cnt + LOCK_W'(1);
            end
            o_lock_timeout <= lock_expire_c;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected {grant,byte} queued at stimulus,
// checked by a monitor on every o_tx_start pulse.
module tb_uart_tx_arbiter;

    logic       i_clock = 1'b0;
    logic       i_reset_n = 1'b0;
    logic [1:0] i_valid = 2'b00;
    logic [7:0] i_data0 = 8'h00;
    logic [7:0] i_data1 = 8'h00;
    logic [1:0] i_lock = 2'b00;
    logic       i_tx_done = 1'b0;
    logic [1:0] o_ready;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_grant;
    logic       o_busy;
    logic [1:0] o_overrun;
    logic       o_lock_timeout;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] sb[$];
    bit         tx_auto = 1'b1;

    uart_tx_arbiter #(
        .UART_DATA_SIZE(8),
        .GAP_CYCLES    (2),
        .LOCK_TIMEOUT  (1024)
    ) dut (
        .i_clock       (i_clock),
        .i_reset_n     (i_reset_n),
        .i_valid       (i_valid),
        .i_data0       (i_data0),
        .i_data1       (i_data1),
        .i_lock        (i_lock),
        .i_tx_done     (i_tx_done),
        .o_ready       (o_ready),
        .o_tx_data     (o_tx_data),
        .o_tx_start    (o_tx_start),
        .o_grant       (o_grant),
        .o_busy        (o_busy),
        .o_overrun     (o_overrun),
        .o_lock_timeout(o_lock_timeout)
    );

    always #5 i_clock = ~i_clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every start pulse must match the head of the scoreboard
    always @(negedge i_clock) begin
        if (i_reset_n && o_tx_start) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start actual=%0h expected=none", o_tx_data);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                chk("tx_data", 32'(o_tx_data), 32'(e[7:0]));
                chk("tx_grant", 32'(o_grant), 32'(e[8]));
            end
        end
    end

    // UART TX model: done tick about 20 clocks after each start
    initial begin
        forever begin
            @(negedge i_clock);
            if (o_tx_start && tx_auto) begin
                repeat (20) @(posedge i_clock);
                #1 i_tx_done = 1'b1;
                @(posedge i_clock);
                #1 i_tx_done = 1'b0;
            end
        end
    end

    task automatic send_byte(input int ch, input logic [7:0] d, input logic lk, input bit wait_rdy);
        int n = 0;
        while (wait_rdy && !o_ready[ch] && n < 500) begin
            @(negedge i_clock);
            n++;
        end
        if (n >= 500) chk("ready_timeout", 32'(o_ready), 32'd3);
        if (ch == 0) i_data0 = d; else i_data1 = d;
        i_lock[ch]  = lk;
        i_valid[ch] = 1'b1;
        repeat (2) @(negedge i_clock);
        i_valid[ch] = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (n < 300) begin
            @(negedge i_clock);
            if (i_tx_done) break;
            n++;
        end
        if (n >= 300) chk("done_timeout", 32'(i_tx_done), 32'd1);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (n < limit && !(!o_busy && o_ready == 2'b11 && sb.size() == 0)) begin
            @(negedge i_clock);
            n++;
        end
        if (n >= limit) chk("idle_timeout", 32'(o_busy), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(o_ready), 32'd3);
        chk({tag, "_tx_data"}, 32'(o_tx_data), 32'd0);
        chk({tag, "_tx_start"}, 32'(o_tx_start), 32'd0);
        chk({tag, "_grant"}, 32'(o_grant), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_overrun"}, 32'(o_overrun), 32'd0);
        chk({tag, "_lock_timeout"}, 32'(o_lock_timeout), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge i_clock);
        chk_reset_outputs("rst");
        i_reset_n = 1'b1;
        @(negedge i_clock);

        // 1: single ch0 byte, latency and ready/busy timing
        sb.push_back({1'b0, 8'hA5});
        i_data0 = 8'hA5; i_lock = 2'b00; i_valid = 2'b01;
        @(negedge i_clock);
        @(negedge i_clock);
        chk("t1_start", 32'(o_tx_start), 32'd1);
        chk("t1_ready_low", 32'(o_ready), 32'd2);
        chk("t1_busy", 32'(o_busy), 32'd1);
        @(negedge i_clock);
        chk("t1_start_one_cycle", 32'(o_tx_start), 32'd0);
        i_valid = 2'b00;
        wait_done();
        @(negedge i_clock);
        chk("t1_ready_at_done", 32'(o_ready), 32'd2);
        chk("t1_busy_gap1", 32'(o_busy), 32'd1);
        @(negedge i_clock);
        chk("t1_ready_after_done", 32'(o_ready), 32'd3);
        chk("t1_busy_gap2", 32'(o_busy), 32'd1);
        @(negedge i_clock);
        chk("t1_busy_idle", 32'(o_busy), 32'd0);

        // 2: simultaneous edges with grant=0 -> ch1 first
        sb.push_back({1'b1, 8'h22});
        sb.push_back({1'b0, 8'h11});
        i_data0 = 8'h11; i_data1 = 8'h22; i_valid = 2'b11;
        repeat (3) @(negedge i_clock);
        i_valid = 2'b00;
        wait_idle(300);
        chk("t2_grant_last", 32'(o_grant), 32'd0);

        // 3: locked ch0 frame of three bytes holds off pending ch1
        sb.push_back({1'b0, 8'hB0});
        sb.push_back({1'b0, 8'hB1});
        sb.push_back({1'b0, 8'hB2});
        sb.push_back({1'b1, 8'hC0});
        send_byte(0, 8'hB0, 1'b1, 1'b1);
        send_byte(1, 8'hC0, 1'b0, 1'b1);
        send_byte(0, 8'hB1, 1'b1, 1'b1);
        send_byte(0, 8'hB2, 1'b0, 1'b1);
        wait_idle(400);
        chk("t3_grant_last", 32'(o_grant), 32'd1);

        // 4: lock owner goes silent, lock times out after 1024 idle clocks
        sb.push_back({1'b0, 8'hD0});
        sb.push_back({1'b1, 8'hE0});
        send_byte(0, 8'hD0, 1'b1, 1'b1);
        send_byte(1, 8'hE0, 1'b0, 1'b1);
        wait_done();
        repeat (1026) @(negedge i_clock);
        chk("t4_timeout_early", 32'(o_lock_timeout), 32'd0);
        chk("t4_no_start_while_locked", 32'(o_tx_start), 32'd0);
        @(negedge i_clock);
        chk("t4_timeout_pulse", 32'(o_lock_timeout), 32'd1);
        @(negedge i_clock);
        chk("t4_timeout_one_cycle", 32'(o_lock_timeout), 32'd0);
        chk("t4_ch1_start", 32'(o_tx_start), 32'd1);
        wait_idle(300);

        // 5: second ch1 edge while pending -> overrun, byte dropped
        sb.push_back({1'b1, 8'hF0});
        send_byte(1, 8'hF0, 1'b0, 1'b1);
        repeat (3) @(negedge i_clock);
        send_byte(1, 8'hF1, 1'b0, 1'b0);
        wait_idle(300);
        chk("t5_overrun", 32'(o_overrun), 32'd2);
        repeat (30) @(negedge i_clock);
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);
        chk("t5_idle", 32'(o_busy), 32'd0);

        // 6: reset during BUSY aborts, then normal operation resumes
        tx_auto = 1'b0;
        sb.push_back({1'b0, 8'h5A});
        send_byte(0, 8'h5A, 1'b0, 1'b1);
        repeat (5) @(negedge i_clock);
        chk("t6_busy_before_reset", 32'(o_busy), 32'd1);
        i_reset_n = 1'b0;
        @(negedge i_clock);
        chk_reset_outputs("t6");
        i_reset_n = 1'b1;
        tx_auto = 1'b1;
        @(negedge i_clock);
        sb.push_back({1'b0, 8'h3C});
        send_byte(0, 8'h3C, 1'b0, 1'b1);
        wait_idle(300);
        chk("t6_grant", 32'(o_grant), 32'd0);
        chk("t6_data", 32'(o_tx_data), 32'h3C);
        chk("end_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
